uart_tx_fifo: RTL and testbench

Parametrised UART transmitter that replaces the single-byte 8N1/8-parity transmitter. Generalises data width, parity mode, stop-bit count and baud divider, and adds an internal TX FIFO so the host can queue frames without waiting for each one to finish. Sits between a host write port (CPU/bus bridge or test driver) and the board serial TX pin.

---
 rtl/uart_tx_fifo.sv | 149 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter with an internal TX FIFO.
// Frames are start + DATA_BITS (LSB first) + optional parity + STOP_BITS, CLK_DIV cycles per bit.
module uart_tx_fifo #(
    parameter int CLK_DIV    = 5208,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 1,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 Reset_n,
    input  logic                 Wr,
    input  logic [DATA_BITS-1:0] Din,
    output logic                 Full,
    output logic [CW-1:0]        Count,
    output logic                 Overflow,
    output logic                 Busy,
    output logic                 Sent,
    output logic                 Sout
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state, state_nx;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count;
    logic [TW-1:0]        timer;
    logic [BW-1:0]        bit_cnt, bit_nx;
    logic                 stop_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 sout_q, sout_nx, sent_q, overflow_q;
    logic                 push, pop, empty, full, bit_done, stop_last, par_bit;

    assign empty     = (count == '0);
    assign full      = (count == CW'(FIFO_DEPTH));
    // Full is judged before any same-cycle pop, so a write while full is always dropped.
    assign push      = Wr && !full;
    assign bit_done  = (timer == TW'(CLK_DIV - 1));
    assign stop_last = (STOP_BITS == 1) || stop_cnt;
    assign par_bit   = (PARITY == 1) ? ~^shift : ^shift;

    // NOTE: storage arrays carry no reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= Din;
        if (pop)
            shift <= mem[rd_ptr];
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            overflow_q <= Wr && full;
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            timer    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            sout_q   <= 1'b1;
            sent_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            timer    <= (state == IDLE || bit_done) ? '0 : timer + TW'(1);
            bit_cnt  <= bit_nx;
            stop_cnt <= (state_nx != STOP) ? 1'b0 :
                        (state == STOP && bit_done) ? 1'b1 : stop_cnt;
            sout_q   <= sout_nx;
            sent_q   <= (state == STOP) && bit_done && stop_last;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_nx = START;
                    pop      = 1'b1;
                end
            end
            START: if (bit_done) state_nx = DATA;
            DATA: begin
                if (bit_done && bit_cnt == BW'(DATA_BITS - 1))
                    state_nx = (PARITY != 0) ? PAR : STOP;
            end
            PAR: if (bit_done) state_nx = STOP;
            STOP: begin
                if (bit_done && stop_last) begin
                    if (!empty) begin
                        state_nx = START;
                        pop      = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Sout is computed from the next state so the registered pin changes on bit boundaries only.
    always_comb begin
        bit_nx  = bit_cnt;
        sout_nx = 1'b1;
        if (state_nx != DATA)
            bit_nx = '0;
        else if (state == DATA && bit_done)
            bit_nx = bit_cnt + BW'(1);
        case (state_nx)
            START:   sout_nx = 1'b0;
            DATA:    sout_nx = shift[bit_nx];
            PAR:     sout_nx = par_bit;
            default: sout_nx = 1'b1;
        endcase
    end

    assign Full     = full;
    assign Count    = count;
    assign Overflow = overflow_q;
    assign Busy     = (state != IDLE) || !empty;
    assign Sent     = sent_q;
    assign Sout     = sout_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: three instances covering odd/even/no parity,
// 7/8 data bits, 1/2 stop bits, FIFO overflow, pop/write collision and async reset.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    localparam int TIMEOUT = 400;

    typedef struct packed {
        logic [8:0] data;
        logic       par;
    } exp_t;

    typedef struct packed {
        logic [7:0] din;
        logic       exp_par;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    int   sent_a_q[$], sent_b_q[$], sent_c_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: odd parity, 8 data bits, 1 stop, CLK_DIV=8, 4-deep FIFO
    logic       wr_a, full_a, ovf_a, busy_a, sent_a, sout_a;
    logic [7:0] din_a;
    logic [2:0] count_a;
    uart_tx_fifo #(.CLK_DIV(8), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .Reset_n(reset_n), .Wr(wr_a), .Din(din_a), .Full(full_a), .Count(count_a),
        .Overflow(ovf_a), .Busy(busy_a), .Sent(sent_a), .Sout(sout_a));

    // Instance B: even parity, 7 data bits, 2 stops, CLK_DIV=16
    logic       wr_b, full_b, ovf_b, busy_b, sent_b, sout_b;
    logic [6:0] din_b;
    logic [2:0] count_b;
    uart_tx_fifo #(.CLK_DIV(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .Reset_n(reset_n), .Wr(wr_b), .Din(din_b), .Full(full_b), .Count(count_b),
        .Overflow(ovf_b), .Busy(busy_b), .Sent(sent_b), .Sout(sout_b));

    // Instance C: no parity, 8 data bits, 1 stop, CLK_DIV=4, 16-deep FIFO
    logic       wr_c, full_c, ovf_c, busy_c, sent_c, sout_c;
    logic [7:0] din_c;
    logic [4:0] count_c;
    uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) dut_c (
        .clk(clk), .Reset_n(reset_n), .Wr(wr_c), .Din(din_c), .Full(full_c), .Count(count_c),
        .Overflow(ovf_c), .Busy(busy_c), .Sent(sent_c), .Sout(sout_c));

    always @(negedge clk) begin
        if (sent_a === 1'b1) sent_a_q.push_back(cyc);
        if (sent_b === 1'b1) sent_b_q.push_back(cyc);
        if (sent_c === 1'b1) sent_c_q.push_back(cyc);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic sout_of(input int sel);
        case (sel)
            0:       return sout_a;
            1:       return sout_b;
            default: return sout_c;
        endcase
    endfunction

    function automatic logic busy_of(input int sel);
        case (sel)
            0:       return busy_a;
            1:       return busy_b;
            default: return busy_c;
        endcase
    endfunction

    function automatic logic model_par(input logic [8:0] d, input int nbits, input int mode);
        int ones = 0;
        for (int i = 0; i < nbits; i++) ones += int'(d[i]);
        return (mode == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
    endfunction

    task automatic write_a(input logic [7:0] d);
        wr_a = 1'b1; din_a = d; @(posedge clk); #1; wr_a = 1'b0;
    endtask

    task automatic write_b(input logic [6:0] d);
        wr_b = 1'b1; din_b = d; @(posedge clk); #1; wr_b = 1'b0;
    endtask

    task automatic write_c(input logic [7:0] d);
        wr_c = 1'b1; din_c = d; @(posedge clk); #1; wr_c = 1'b0;
    endtask

    // Wait for a start bit, then sample each bit at its midpoint.
    task automatic capture(input int sel, input int div, input int nbits, input int pmode,
                           input int nstop, output logic [8:0] data, output logic par,
                           output logic stop_ok, output logic start_ok, output int start_cyc);
        int n = 0;
        data = '0; par = 1'b0; stop_ok = 1'b1; start_ok = 1'b0; start_cyc = 0;
        while (sout_of(sel) !== 1'b0 && n < TIMEOUT) begin
            @(posedge clk); #1; n++;
        end
        if (n < TIMEOUT) begin
            start_cyc = cyc;
            repeat (div / 2) @(posedge clk);
            #1;
            start_ok = (sout_of(sel) === 1'b0);
            for (int i = 0; i < nbits; i++) begin
                repeat (div) @(posedge clk);
                #1;
                data[i] = sout_of(sel);
            end
            if (pmode != 0) begin
                repeat (div) @(posedge clk);
                #1;
                par = sout_of(sel);
            end
            for (int i = 0; i < nstop; i++) begin
                repeat (div) @(posedge clk);
                #1;
                if (sout_of(sel) !== 1'b1) stop_ok = 1'b0;
            end
        end
    endtask

    task automatic check_frame(input int sel, input int div, input int nbits, input int pmode,
                               input int nstop, input string tag, output int start_cyc);
        logic [8:0] data;
        logic       par, stop_ok, start_ok;
        exp_t       e;
        capture(sel, div, nbits, pmode, nstop, data, par, stop_ok, start_ok, start_cyc);
        check({tag, "_start"}, start_ok, 1);
        check({tag, "_sb_nonempty"}, sb.size() != 0, 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_data"}, data, e.data);
            if (pmode != 0) check({tag, "_parity"}, par, e.par);
        end
        check({tag, "_stop"}, stop_ok, 1);
    endtask

    task automatic wait_idle(input int sel, input string tag);
        int n = 0;
        while (busy_of(sel) !== 1'b0 && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_idle"}, busy_of(sel), 0);
    endtask

    task automatic wait_sent(input int want, input int sel);
        int n = 0;
        while (n < TIMEOUT && ((sel == 0 && sent_a_q.size() < want) ||
                               (sel == 1 && sent_b_q.size() < want) ||
                               (sel == 2 && sent_c_q.size() < want))) begin
            @(posedge clk); #1; n++;
        end
    endtask

    initial begin
        vec_t       vec [6];
        logic [7:0] ovf_bytes [6];
        logic [7:0] pc_bytes [5];
        logic [7:0] c_bytes [3];
        int         k, t0, st, errs;
        int         cst [3];

        vec[0] = '{8'hA5, 1'b1};
        vec[1] = '{8'h00, 1'b1};
        vec[2] = '{8'h01, 1'b0};
        vec[3] = '{8'h80, 1'b0};
        vec[4] = '{8'h7F, 1'b0};
        vec[5] = '{8'h3C, 1'b1};
        ovf_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        pc_bytes  = '{8'h9A, 8'hB7, 8'hC3, 8'hD0, 8'hE1};
        c_bytes   = '{8'h31, 8'hC4, 8'h0F};

        reset_n = 1'b0;
        wr_a = 1'b0; din_a = '0; wr_b = 1'b0; din_b = '0; wr_c = 1'b0; din_c = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;

        // Reset state
        check("rst_sout_a", sout_a, 1);
        check("rst_busy_a", busy_a, 0);
        check("rst_full_a", full_a, 0);
        check("rst_count_a", count_a, 0);
        check("rst_ovf_a", ovf_a, 0);
        check("rst_sent_a", sent_a, 0);
        check("rst_sout_b", sout_b, 1);
        check("rst_sout_c", sout_c, 1);
        check("rst_busy_c", busy_c, 0);

        // Latency and frame length on A
        sent_a_q.delete();
        write_a(8'hA5);
        check("lat_count", count_a, 1);
        check("lat_sout_idle", sout_a, 1);
        check("lat_busy", busy_a, 1);
        @(posedge clk); #1;
        check("lat_sout_start", sout_a, 0);
        check("lat_count_pop", count_a, 0);
        t0 = cyc;
        wait_sent(1, 0);
        check("a_sent_seen", sent_a_q.size(), 1);
        if (sent_a_q.size() > 0) check("a_sent_time", sent_a_q[0] - t0, 88);
        check("a_sent_pulse_width", sent_a, 0);
        check("a_busy_after", busy_a, 0);

        // Table-driven frames on A
        for (int i = 0; i < 6; i++) begin
            sb.push_back('{{1'b0, vec[i].din}, vec[i].exp_par});
            write_a(vec[i].din);
            check_frame(0, 8, 8, 1, 1, $sformatf("vec%0d", i), st);
            wait_idle(0, $sformatf("vec%0d", i));
        end

        // Even parity, 7 bits, 2 stops on B
        sent_b_q.delete();
        sb.push_back('{9'h055, 1'b0});
        write_b(7'h55);
        check_frame(1, 16, 7, 2, 2, "b55", st);
        wait_sent(1, 1);
        check("b_sent_seen", sent_b_q.size(), 1);
        if (sent_b_q.size() > 0) check("b_frame_len", sent_b_q[0] - st, 176);
        wait_idle(1, "b55");

        // Back-to-back frames with no gap on C
        sent_c_q.delete();
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    sb.push_back('{{1'b0, c_bytes[i]}, 1'b0});
                    write_c(c_bytes[i]);
                end
            end
            begin
                for (int i = 0; i < 3; i++) check_frame(2, 4, 8, 0, 1, $sformatf("c%0d", i), cst[i]);
            end
        join
        check("c_gap01", cst[1] - cst[0], 40);
        check("c_gap12", cst[2] - cst[1], 40);
        wait_sent(3, 2);
        check("c_sent_count", sent_c_q.size(), 3);
        if (sent_c_q.size() == 3) begin
            check("c_sent_first", sent_c_q[0] - cst[0], 40);
            check("c_sent_gap01", sent_c_q[1] - sent_c_q[0], 40);
            check("c_sent_gap12", sent_c_q[2] - sent_c_q[1], 40);
        end
        wait_idle(2, "c");

        // Overflow: six consecutive writes into a 4-deep FIFO
        sent_a_q.delete();
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    if (i < 5) sb.push_back('{{1'b0, ovf_bytes[i]}, model_par({1'b0, ovf_bytes[i]}, 8, 1)});
                    write_a(ovf_bytes[i]);
                    if (i == 4) begin
                        check("ovf_full", full_a, 1);
                        check("ovf_count4", count_a, 4);
                        check("ovf_no_pulse_yet", ovf_a, 0);
                    end
                end
                check("ovf_pulse", ovf_a, 1);
                check("ovf_count_hold", count_a, 4);
                @(posedge clk); #1;
                check("ovf_pulse_end", ovf_a, 0);
            end
            begin
                for (int i = 0; i < 5; i++) check_frame(0, 8, 8, 1, 1, $sformatf("ovf%0d", i), st);
            end
        join
        wait_idle(0, "ovf");
        @(posedge clk); #1;
        check("ovf_frames", sent_a_q.size(), 5);
        check("ovf_sb_drained", sb.size(), 0);

        // Write while full on the very edge the FSM pops
        sent_a_q.delete();
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    sb.push_back('{{1'b0, pc_bytes[i]}, model_par({1'b0, pc_bytes[i]}, 8, 1)});
                    write_a(pc_bytes[i]);
                    if (i == 0) k = cyc;
                end
                while (cyc < k + 88) begin
                    @(posedge clk); #1;
                end
                check("pc_full_before", full_a, 1);
                check("pc_count_before", count_a, 4);
                wr_a = 1'b1; din_a = 8'hEE;
                @(posedge clk); #1;
                wr_a = 1'b0;
                check("pc_ovf", ovf_a, 1);
                check("pc_count_after", count_a, 3);
                check("pc_full_after", full_a, 0);
            end
            begin
                for (int i = 0; i < 5; i++) check_frame(0, 8, 8, 1, 1, $sformatf("pc%0d", i), st);
            end
        join
        wait_idle(0, "pc");
        @(posedge clk); #1;
        check("pc_frames", sent_a_q.size(), 5);
        check("pc_sb_drained", sb.size(), 0);

        // Async reset mid-DATA with two frames queued
        write_a(8'h00);
        k = cyc;
        write_a(8'h00);
        write_a(8'h00);
        while (cyc < k + 29) begin
            @(posedge clk); #1;
        end
        check("rstmid_sout_before", sout_a, 0);
        check("rstmid_count_before", count_a, 2);
        #2 reset_n = 1'b0;
        #1;
        check("rstmid_sout", sout_a, 1);
        check("rstmid_count", count_a, 0);
        check("rstmid_busy", busy_a, 0);
        check("rstmid_full", full_a, 0);
        sent_a_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        errs = 0;
        repeat (150) begin
            @(posedge clk); #1;
            if (sout_a !== 1'b1 || busy_a !== 1'b0 || count_a !== 3'd0) errs++;
        end
        check("rstmid_quiet", errs, 0);
        check("rstmid_no_sent", sent_a_q.size(), 0);

        // Recovery after reset
        sb.push_back('{9'h05A, model_par(9'h05A, 8, 1)});
        write_a(8'h5A);
        check_frame(0, 8, 8, 1, 1, "recover", st);
        wait_idle(0, "recover");
        check("final_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
